stopwatch_display_driver: RTL and testbench

Downstream of the stopwatch counter. Consumes the four BCD digits (minutes tens/ones, seconds tens/ones) and the ADJ/SEL switch state, and time-multiplexes them onto a 4-digit common-anode seven-segment display. A blank cycle precedes each digit change to suppress ghosting. In adjust mode the selected digit blinks, and the decimal point separates minutes from seconds.

---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/stopwatch_display_driver.sv | 127 ++++++++++++
 tb/tb_stopwatch_display_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch display path: segment patterns,
// digit/select indices and the active-low "off" levels for an/dp.
package stopwatch_pkg;

   // Segment order is {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] DIG_SEC_ONES = 2'd0;
   localparam logic [1:0] DIG_SEC_TENS = 2'd1;
   localparam logic [1:0] DIG_MIN_ONES = 2'd2;
   localparam logic [1:0] DIG_MIN_TENS = 2'd3;

   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam logic       DP_OFF = 1'b1;
   localparam logic       DP_ON  = 1'b0;

   function automatic logic [3:0] an_select(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; purely combinational.
// Codes 10-15 are not valid BCD and render as a dash.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stopwatch_display_driver.sv
// Time-multiplexes a frame-coherent snapshot of four BCD digits onto a 4-digit
// common-anode display; registered outputs, one blank cycle before each digit.
module stopwatch_display_driver
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int BLINK_HZ   = 2
)
(
   input  logic       clk_c,
   input  logic       reset_c,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_ones,
   input  logic       ADJ,
   input  logic [1:0] SEL,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int REFRESH_DIV = CLK_HZ / REFRESH_HZ;
   localparam int BLINK_HALF  = CLK_HZ / (2 * BLINK_HZ);
   localparam int RW          = $clog2(REFRESH_DIV);
   localparam int BW          = $clog2(BLINK_HALF);

   logic [RW-1:0]      ref_cnt;
   logic               tick;
   logic [1:0]         idx;
   logic [BW-1:0]      blink_cnt;
   logic               blink_on;
   logic [3:0][3:0]    snap;
   logic               adj_meta, adj_sync;
   logic [1:0]         sel_meta, sel_sync;
   logic [6:0]         dig_seg;
   logic [6:0]         seg_nxt;
   logic [3:0]         an_nxt;
   logic               dp_nxt;

   assign tick = (ref_cnt == RW'(REFRESH_DIV - 1));

   always_ff @(posedge clk_c or posedge reset_c) begin
      if (reset_c) begin
         ref_cnt <= '0;
         idx     <= DIG_SEC_ONES;
      end else if (tick) begin
         ref_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_c or posedge reset_c) begin
      if (reset_c) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Capture on the last slot's tick so a whole frame shows one coherent time.
   always_ff @(posedge clk_c or posedge reset_c) begin
      if (reset_c) begin
         snap <= '0;
      end else if (tick && idx == DIG_MIN_TENS) begin
         snap[DIG_SEC_ONES] <= sec_ones;
         snap[DIG_SEC_TENS] <= sec_tens;
         snap[DIG_MIN_ONES] <= min_ones;
         snap[DIG_MIN_TENS] <= min_tens;
      end
   end

   always_ff @(posedge clk_c or posedge reset_c) begin
      if (reset_c) begin
         adj_meta <= 1'b0;
         adj_sync <= 1'b0;
         sel_meta <= 2'b00;
         sel_sync <= 2'b00;
      end else begin
         adj_meta <= ADJ;
         adj_sync <= adj_meta;
         sel_meta <= SEL;
         sel_sync <= sel_meta;
      end
   end

   seg7_decode u_decode (
      .digit (snap[idx]),
      .seg   (dig_seg)
   );

   always_comb begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_BLANK;
      dp_nxt  = DP_OFF;
      if (!tick) begin
         an_nxt  = an_select(idx);
         seg_nxt = dig_seg;
         dp_nxt  = (idx == DIG_MIN_ONES) ? DP_ON : DP_OFF;
         // Anode stays on while blanked so the scan timing never changes.
         if (adj_sync && sel_sync == idx && !blink_on) begin
            seg_nxt = SEG_BLANK;
            dp_nxt  = DP_OFF;
         end
      end
   end

   always_ff @(posedge clk_c or posedge reset_c) begin
      if (reset_c) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= DP_OFF;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Scoreboard bench: a cycle model derived from the elapsed-cycle count pushes
// the expected {an,seg,dp} at each rising edge; the falling edge pops and compares.
module tb_stopwatch_display_driver;

   logic       clk_c = 1'b0;
   logic       reset_c;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       ADJ;
   logic [1:0] SEL;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int nvec = 0;
   int nerr = 0;
   int k    = 0;
   logic [11:0] exp_q[$];
   logic [3:0]  snap_m [4];
   logic        adj_h1, adj_h2;
   logic [1:0]  sel_h1, sel_h2;

   localparam logic [11:0] ALL_OFF = 12'hFFF;

   always #5 clk_c = ~clk_c;

   stopwatch_display_driver #(
      .CLK_HZ     (1000),
      .REFRESH_HZ (100),
      .BLINK_HZ   (50)
   ) dut (
      .clk_c    (clk_c),
      .reset_c  (reset_c),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .ADJ      (ADJ),
      .SEL      (SEL),
      .seg      (seg),
      .an       (an),
      .dp       (dp)
   );

   task automatic check_out(input string tag, input logic [11:0] got, input logic [11:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s at k=%0d: an/seg/dp got %b_%b_%b want %b_%b_%b", tag, k,
                  got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // k counts rising edges since reset release; the model state before edge k
   // has phase (k-1)%10 in the slot, slot ((k-1)/10)%4, blink toggled (k-1)/10 times.
   always @(posedge clk_c) begin
      logic [11:0] e;
      logic [3:0]  an_e;
      int          ph, slot;
      logic        bon;
      if (reset_c) begin
         k = 0;
         for (int i = 0; i < 4; i++) snap_m[i] = 4'd0;
         adj_h1 = 1'b0; adj_h2 = 1'b0;
         sel_h1 = 2'b00; sel_h2 = 2'b00;
         e = ALL_OFF;
      end else begin
         k++;
         ph   = (k - 1) % 10;
         slot = ((k - 1) / 10) % 4;
         bon  = (((k - 1) / 10) % 2) == 0;
         if (ph == 9) begin
            e = ALL_OFF;
         end else begin
            an_e = 4'b1111;
            an_e[slot] = 1'b0;
            e = {an_e, ref_seg(snap_m[slot]), (slot == 2) ? 1'b0 : 1'b1};
            if (adj_h2 && int'(sel_h2) == slot && !bon) e[7:0] = 8'hFF;
         end
         if (k % 40 == 0) begin
            snap_m[0] = sec_ones;
            snap_m[1] = sec_tens;
            snap_m[2] = min_ones;
            snap_m[3] = min_tens;
         end
         adj_h2 = adj_h1; adj_h1 = ADJ;
         sel_h2 = sel_h1; sel_h1 = SEL;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk_c) begin
      if (exp_q.size() > 0) check_out("scan", {an, seg, dp}, exp_q.pop_front());
   end

   initial begin
      reset_c  = 1'b0;
      min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
      ADJ      = 1'b0; SEL = 2'b00;
      #1 reset_c = 1'b1;
      #1 check_out("rst_init", {an, seg, dp}, ALL_OFF);

      repeat (3) @(negedge clk_c);
      reset_c = 1'b0;
      repeat (130) @(negedge clk_c);

      // Mid-frame change: must not appear until after the next capture.
      sec_ones = 4'd5;
      repeat (90) @(negedge clk_c);

      sec_tens = 4'd12;
      repeat (90) @(negedge clk_c);

      ADJ = 1'b1; SEL = 2'b10;
      repeat (90) @(negedge clk_c);
      SEL = 2'b01;
      repeat (90) @(negedge clk_c);

      // Drop ADJ early in the sec_tens slot, where that digit is blinked off.
      for (int i = 0; i < 100 && (k % 40) != 12; i++) @(negedge clk_c);
      ADJ = 1'b0;
      repeat (45) @(negedge clk_c);

      repeat (17) @(negedge clk_c);
      #2 reset_c = 1'b1;
      #1 check_out("rst_async", {an, seg, dp}, ALL_OFF);
      @(negedge clk_c);
      @(negedge clk_c);
      reset_c = 1'b0;

      ADJ = 1'b1; SEL = 2'b11;
      repeat (90) @(negedge clk_c);
      ADJ = 1'b0;

      min_tens = 4'd5; min_ones = 4'd9; sec_tens = 4'd5; sec_ones = 4'd9;
      repeat (50) @(negedge clk_c);
      min_tens = 4'd0; min_ones = 4'd0; sec_tens = 4'd0; sec_ones = 4'd0;
      repeat (60) @(negedge clk_c);

      @(negedge clk_c);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
